// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with shadow/display banks and frame-aligned commit.
// Optional SEG_LZ_BLANK_EN: suppress leading-zero digits above digit 0.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_idx,
  input  logic [4:0]                    wr_data,
  input  logic                          commit,
  output logic [4:0]                    dec_value,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PS_W  = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_BLANK
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [PS_W-1:0]  r_cnt;
  logic [PS_W-1:0]  w_cnt_nxt;
  logic             r_pending;
  logic [4:0]       r_shadow  [NUM_DIGITS];
  logic [4:0]       r_display [NUM_DIGITS];

  logic w_last_idx;
  logic w_cnt_done;
  logic w_frame_end;
  logic w_xfer;
  logic w_wr_acc;
  logic w_commit_acc;

  assign w_last_idx   = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_cnt_done   = (r_cnt == PS_W'(PRESCALE - 1));
  assign w_frame_end  = (r_state == S_BLANK) && w_last_idx && enable;
  assign w_xfer       = r_pending && ((r_state == S_IDLE) || w_frame_end);
  assign w_wr_acc     = wr_valid && !r_pending;
  assign w_commit_acc = commit && !r_pending;

  assign wr_ready   = !r_pending;
  assign frame_done = w_frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_DRIVE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        S_DRIVE: begin
          if (w_cnt_done) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + PS_W'(1);
          end
        end
        S_BLANK: begin
          w_state_nxt = S_DRIVE;
          w_idx_nxt   = w_last_idx ? '0 : r_idx + IDX_W'(1);
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Writes to indices with no backing digit simply match no slot and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i]  <= '0;
        r_display[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (w_wr_acc && (wr_idx == IDX_W'(i))) begin
          r_shadow[i] <= wr_data;
        end
        if (w_xfer) begin
          r_display[i] <= r_shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (w_xfer) begin
      r_pending <= 1'b0;
    end else if (w_commit_acc) begin
      r_pending <= 1'b1;
    end
  end

`ifdef SEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] w_lz;

  // w_lz[i]: digit i and every digit above it hold 5'b00000.
  always_comb begin
    logic v_hi_zero;
    v_hi_zero = 1'b1;
    w_lz      = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      v_hi_zero = v_hi_zero && (r_display[NUM_DIGITS - 1 - k] == 5'b00000);
      w_lz[NUM_DIGITS - 1 - k] = v_hi_zero;
    end
  end
`endif

  always_comb begin
    digit_sel = '0;
    dec_value = '0;
    case (r_state)
      S_DRIVE: begin
        dec_value = r_display[r_idx];
        digit_sel = NUM_DIGITS'(1) << r_idx;
`ifdef SEG_LZ_BLANK_EN
        if ((r_idx != '0) && w_lz[r_idx]) begin
          digit_sel = '0;
        end
`endif
      end
      S_BLANK: begin
        dec_value = r_display[r_idx];
      end
      default: begin
        digit_sel = '0;
        dec_value = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl at NUM_DIGITS=4, PRESCALE=4 (20-cycle frame).
module tb_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_idx = '0;
  logic [4:0] wr_data = '0;
  logic       commit = 1'b0;
  logic [4:0] dec_value;
  logic [3:0] digit_sel;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  bit scanning = 1'b0;

  seg_scan_ctrl #(.NUM_DIGITS(4), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_data(wr_data), .commit(commit),
    .dec_value(dec_value), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(digit_sel) > 1) begin
        errors++;
        $display("FAIL onehot: digit_sel=%b, required at most one bit set", digit_sel);
      end
    end
  end

  // pos tracks the frame position: digit*5 + phase, phase 4 is the blank cycle.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (scanning) pos = (pos + 1) % 20;
    end
  endtask

  task automatic run_to(input int d, input int c);
    step(((d * 5 + c) - pos + 20) % 20);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; commit = 1'b0;
    scanning = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic load(input logic [4:0] v0, input logic [4:0] v1,
                      input logic [4:0] v2, input logic [4:0] v3);
    logic [4:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_idx = 2'(i); wr_data = v[i];
      step(1);
    end
    wr_valid = 1'b0;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(1);
  endtask

  task automatic start_scan();
    enable = 1'b1;
    step(1);
    scanning = 1'b1;
    pos = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (digit_sel !== 4'b0000 || dec_value !== 5'h00 || frame_done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: sel=%b dec=%h fd=%b rdy=%b, required 0000 00 0 1",
               digit_sel, dec_value, frame_done, wr_ready);
    end
    do_reset();
    checks++;
    if (digit_sel !== 4'b0000 || dec_value !== 5'h00 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: sel=%b dec=%h rdy=%b, required 0000 00 1",
               digit_sel, dec_value, wr_ready);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_sel;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_idx = 2'(i); wr_data = 5'(i + 1);
      step(1);
    end
    wr_valid = 1'b0;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_commit_pending: wr_ready=%b, required 0", wr_ready);
    end
    step(1);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_commit_xfer: wr_ready=%b, required 1", wr_ready);
    end
    start_scan();
    for (int n = 0; n < 40; n++) begin
      exp_sel = (pos % 5 == 4) ? 4'b0000 : 4'(1 << (pos / 5));
      checks++;
      if (digit_sel !== exp_sel || dec_value !== 5'(pos / 5 + 1) || frame_done !== (pos == 19)) begin
        errors++;
        $display("FAIL scan_pos%0d: sel=%b dec=%h fd=%b, required %b %h %b", pos,
                 digit_sel, dec_value, frame_done, exp_sel, 5'(pos / 5 + 1), (pos == 19));
      end
      step(1);
    end
  endtask

  task automatic test_commit_midframe();
    do_reset();
    load(5'h01, 5'h02, 5'h03, 5'h04);
    start_scan();
    wr_valid = 1'b1; wr_idx = 2'd2; wr_data = 5'h1A;
    step(1);
    wr_valid = 1'b0;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_commit_ready: wr_ready=%b, required 0", wr_ready);
    end
    run_to(2, 0);
    checks++;
    if (digit_sel !== 4'b0100 || dec_value !== 5'h03 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_commit_old: sel=%b dec=%h rdy=%b, required 0100 03 0",
               digit_sel, dec_value, wr_ready);
    end
    run_to(3, 4);
    checks++;
    if (frame_done !== 1'b1 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_commit_boundary: fd=%b rdy=%b, required 1 0", frame_done, wr_ready);
    end
    step(1);
    checks++;
    if (wr_ready !== 1'b1 || dec_value !== 5'h01) begin
      errors++;
      $display("FAIL mid_commit_released: rdy=%b dec=%h, required 1 01", wr_ready, dec_value);
    end
    run_to(2, 0);
    checks++;
    if (digit_sel !== 4'b0100 || dec_value !== 5'h1A) begin
      errors++;
      $display("FAIL mid_commit_new: sel=%b dec=%h, required 0100 1a", digit_sel, dec_value);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load(5'h01, 5'h02, 5'h03, 5'h04);
    start_scan();
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 5'h09; commit = 1'b1;
    step(1);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wc_same_pending: wr_ready=%b, required 0", wr_ready);
    end
    wr_data = 5'h0F;
    step(1);
    wr_valid = 1'b0; commit = 1'b0;
    run_to(1, 0);
    checks++;
    if (dec_value !== 5'h02) begin
      errors++;
      $display("FAIL wc_same_old: dec=%h, required 02", dec_value);
    end
    run_to(3, 4);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wc_same_fd: fd=%b, required 1", frame_done);
    end
    step(1);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wc_same_rearm: wr_ready=%b, required 1", wr_ready);
    end
    run_to(1, 0);
    checks++;
    if (digit_sel !== 4'b0010 || dec_value !== 5'h09) begin
      errors++;
      $display("FAIL wc_same_new: sel=%b dec=%h, required 0010 09", digit_sel, dec_value);
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    load(5'h01, 5'h02, 5'h03, 5'h04);
    start_scan();
    run_to(2, 1);
    enable = 1'b0;
    scanning = 1'b0;
    step(1);
    checks++;
    if (digit_sel !== 4'b0000 || frame_done !== 1'b0 || dec_value !== 5'h00) begin
      errors++;
      $display("FAIL drop_idle: sel=%b fd=%b dec=%h, required 0000 0 00",
               digit_sel, frame_done, dec_value);
    end
    for (int n = 0; n < 25; n++) begin
      step(1);
      checks++;
      if (frame_done !== 1'b0 || digit_sel !== 4'b0000) begin
        errors++;
        $display("FAIL drop_quiet%0d: fd=%b sel=%b, required 0 0000", n, frame_done, digit_sel);
      end
    end
    start_scan();
    checks++;
    if (digit_sel !== 4'b0001 || dec_value !== 5'h01) begin
      errors++;
      $display("FAIL reenable_d0: sel=%b dec=%h, required 0001 01", digit_sel, dec_value);
    end
    step(3);
    checks++;
    if (digit_sel !== 4'b0001) begin
      errors++;
      $display("FAIL reenable_hold: sel=%b, required 0001", digit_sel);
    end
    step(1);
    checks++;
    if (digit_sel !== 4'b0000 || dec_value !== 5'h01) begin
      errors++;
      $display("FAIL reenable_blank: sel=%b dec=%h, required 0000 01", digit_sel, dec_value);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    load(5'h01, 5'h02, 5'h03, 5'h04);
    start_scan();
    wr_valid = 1'b1; wr_idx = 2'd0; wr_data = 5'h1F; commit = 1'b1;
    step(1);
    wr_valid = 1'b0; commit = 1'b0;
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_pending: wr_ready=%b, required 0", wr_ready);
    end
    run_to(2, 2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (digit_sel !== 4'b0000 || dec_value !== 5'h00 || frame_done !== 1'b0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: sel=%b dec=%h fd=%b rdy=%b, required 0000 00 0 1",
               digit_sel, dec_value, frame_done, wr_ready);
    end
    enable = 1'b0;
    scanning = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
    start_scan();
    checks++;
    if (digit_sel !== 4'b0001 || dec_value !== 5'h00) begin
      errors++;
      $display("FAIL rst_mid_d0: sel=%b dec=%h, required 0001 00", digit_sel, dec_value);
    end
    run_to(1, 0);
    checks++;
    if (dec_value !== 5'h00) begin
      errors++;
      $display("FAIL rst_mid_d1: dec=%h, required 00", dec_value);
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
`ifdef SEG_LZ_BLANK_EN
    exp_a = '{4'b0001, 4'b0010, 4'b0000, 4'b0000};
    exp_b = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
`else
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_b = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    do_reset();
    load(5'h00, 5'h07, 5'h00, 5'h00);
    start_scan();
    for (int d = 0; d < 4; d++) begin
      run_to(d, 1);
      checks++;
      if (digit_sel !== exp_a[d] || dec_value !== ((d == 1) ? 5'h07 : 5'h00)) begin
        errors++;
        $display("FAIL lz_0700_d%0d: sel=%b dec=%h, required %b %h", d, digit_sel, dec_value,
                 exp_a[d], ((d == 1) ? 5'h07 : 5'h00));
      end
    end
    run_to(3, 4);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL lz_fd: fd=%b, required 1", frame_done);
    end
    do_reset();
    load(5'h00, 5'h00, 5'h00, 5'h00);
    start_scan();
    for (int d = 0; d < 4; d++) begin
      run_to(d, 2);
      checks++;
      if (digit_sel !== exp_b[d]) begin
        errors++;
        $display("FAIL lz_zero_d%0d: sel=%b, required %b", d, digit_sel, exp_b[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_commit_midframe();
    test_back_to_back();
    test_enable_drop();
    test_reset_midframe();
    test_leading_zero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter PRESCALE, default 1024, clk cycles each digit is driven (>=2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  scan enable; 0 blanks all digits.
REQ-006 wr_valid  input  1  shadow write request.
REQ-007 wr_ready  output  1  shadow write may be accepted.
REQ-008 wr_idx  input  $clog2(NUM_DIGITS)  target digit; writes with idx >= NUM_DIGITS are accepted and discarded.
REQ-009 wr_data  input  5  bit4 decimal point, bits3:0 hex nibble.
REQ-010 commit  input  1  single-cycle request to transfer shadow to display bank.
REQ-011 dec_value  output  5  value for the shared segment decoder (bit4 dp, bits3:0 nibble).
REQ-012 digit_sel  output  NUM_DIGITS  one-hot active-high digit enable; bit 0 is least significant digit.
REQ-013 frame_done  output  1  one-cycle pulse at end of each full scan.

Function
REQ-014 Two register banks, shadow and display, each NUM_DIGITS x 5 bits; only display bank drives dec_value.
REQ-015 Write accepted when wr_valid && wr_ready; shadow[wr_idx] <= wr_data at that edge.
REQ-016 commit when no commit pending sets pending; commit while pending is ignored.
REQ-017 wr_ready = !pending; write and commit in same cycle: write accepted and included in the transfer.
REQ-018 FSM states IDLE, DRIVE, BLANK.
REQ-019 IDLE: digit_sel = 0, prescaler = 0, scan index = 0; enable=1 -> DRIVE next cycle.
REQ-020 DRIVE: digit_sel = onehot(index), dec_value = display[index]; prescaler increments each cycle.
REQ-021 DRIVE with prescaler = PRESCALE-1 -> BLANK next cycle, prescaler cleared; each digit driven exactly PRESCALE cycles.
REQ-022 BLANK lasts exactly 1 cycle: digit_sel = 0, dec_value held; index <= (index+1) mod NUM_DIGITS; -> DRIVE.
REQ-023 BLANK with index = NUM_DIGITS-1: frame_done = 1 that cycle; if pending, display <= shadow at that edge and pending cleared.
REQ-024 IDLE with pending: display <= shadow and pending cleared on the next edge (static updates while disabled).
REQ-025 enable=0 in any state -> IDLE next cycle; index and prescaler cleared; shadow, display, pending retained; no frame_done.
REQ-026 Frame period = NUM_DIGITS x (PRESCALE+1) cycles.
REQ-027 digit_sel never has more than one bit set in any cycle.

Reset
REQ-028 rst_n low asynchronously forces: state IDLE, index 0, prescaler 0, pending 0, both banks 0.
REQ-029 During and after reset until scanning: digit_sel 0, dec_value 0, frame_done 0, wr_ready 1.
REQ-030 Reset mid-frame abandons the frame; no frame_done and no transfer occur.

Configuration
REQ-031 Macro SEG_LZ_BLANK_EN defined: in DRIVE, digit_sel is forced 0 for index > 0 when display[index] and every higher digit equal 5'b00000; timing, index stepping and frame_done unchanged; digit 0 always shown.
REQ-032 Macro SEG_LZ_BLANK_EN undefined: every digit driven per REQ-020 regardless of value.

Verification (NUM_DIGITS=4, PRESCALE=4)
REQ-033 Reset, write idx0..3 = 1,2,3,4, commit, enable=1 -> digit_sel 0001/0010/0100/1000 for 4 cycles each, dec_value 1..4, one-cycle 0000 gap between; frame_done every 20 cycles.
REQ-034 Commit mid-frame with shadow[2]=5'h1A -> display unchanged until BLANK after digit 3, then dec_value 5'h1A on digit 2; wr_ready low from commit until that transfer.
REQ-035 wr_valid=1 and commit=1 same cycle, idx1=9 -> write accepted, digit 1 shows 9 after frame boundary; second commit while pending has no effect.
REQ-036 enable dropped while digit 2 driven -> digit_sel 0 next cycle, no frame_done; re-enable -> scan restarts at digit 0, prescaler from 0.
REQ-037 rst_n low mid-frame with pending set -> outputs 0, wr_ready 1 immediately; display bank 0 after release.
REQ-038 With SEG_LZ_BLANK_EN, display = {0,0,7,0} (idx3..0) -> digits 3 and 2 blanked, digits 1 and 0 driven; display all 0 -> only digit 0 driven.
